twos_complement_to_int: RTL and testbench

- Converts a signed two's-complement word into its unsigned magnitude, and reports the sign separately.
- Used by the floating-point control unit to turn signed bit-position distances into shift or increment amounts. Direction is taken from the sign.
- Callers sign-extend narrower fields (8-bit, 23-bit) to WIDTH before presenting them.
- The stage is registered, with a valid qualifier.

---
 rtl/fp_pkg.sv | 11 +
 rtl/twos_abs_comb.sv | 22 ++
 rtl/twos_complement_to_int.sv | 45 ++++
 tb/tb_twos_complement_to_int.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and constants for the floating-point control datapath.
package fp_pkg;

    localparam int FP_DIST_WIDTH = 64;

    // Most-negative two's-complement pattern of the given width, right-aligned.
    function automatic logic [FP_DIST_WIDTH-1:0] minPattern(input int width);
        return FP_DIST_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/twos_abs_comb.sv
// twos_abs_comb: combinational magnitude, sign and most-negative detect of a two's-complement word.
module twos_abs_comb
    import fp_pkg::*;
#(
    parameter int WIDTH = FP_DIST_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] mag,
    output logic             neg,
    output logic             min
);

    localparam logic [WIDTH-1:0] MIN_VALUE = WIDTH'(minPattern(WIDTH));

    // The most-negative input wraps to itself, which read as unsigned is its true magnitude.
    always_comb begin
        neg = value[WIDTH-1];
        mag = neg ? ~value + WIDTH'(1) : value;
        min = value == MIN_VALUE;
    end

endmodule

// File: rtl/twos_complement_to_int.sv
// twos_complement_to_int: registered two's-complement to unsigned magnitude with sign and valid.
module twos_complement_to_int
    import fp_pkg::*;
#(
    parameter int WIDTH = FP_DIST_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] twos_complement_value,
    output logic [WIDTH-1:0] result,
    output logic             is_negative,
    output logic             is_min,
    output logic             out_valid
);

    logic [WIDTH-1:0] absMag;
    logic             absNeg;
    logic             absMin;

    twos_abs_comb #(.WIDTH(WIDTH)) absCore (
        .value(twos_complement_value),
        .mag  (absMag),
        .neg  (absNeg),
        .min  (absMin)
    );

    // Data registers only load on a valid capture; out_valid depends on in_valid alone so it never goes X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result      <= '0;
            is_negative <= 1'b0;
            is_min      <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result      <= absMag;
                is_negative <= absNeg;
                is_min      <= absMin;
            end
        end
    end

endmodule

// File: tb/tb_twos_complement_to_int.sv
// tb_twos_complement_to_int: table-driven scoreboard bench for the 64-bit and 8-bit magnitude stage.
module tb_twos_complement_to_int;

    typedef struct {
        logic [63:0] value;
        logic [63:0] mag;
        logic        neg;
        logic        min;
    } vec_t;

    typedef struct {
        logic [63:0] mag;
        logic        neg;
        logic        min;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid64, inValid8;
    logic [63:0] value64, result64;
    logic [7:0]  value8, result8;
    logic        neg64, min64, outValid64;
    logic        neg8, min8, outValid8;

    exp_t q64[$];
    exp_t q8[$];
    int   tests = 0;
    int   fails = 0;

    twos_complement_to_int #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(inValid64), .twos_complement_value(value64),
        .result(result64), .is_negative(neg64), .is_min(min64), .out_valid(outValid64)
    );

    twos_complement_to_int #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(inValid8), .twos_complement_value(value8),
        .result(result8), .is_negative(neg8), .is_min(min8), .out_valid(outValid8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon64
        exp_t e;
        if (!reset && outValid64) begin
            if (q64.size() == 0) check("spurious out_valid64", outValid64, 0);
            else begin
                e = q64.pop_front();
                check("result64", result64, e.mag);
                check("is_negative64", neg64, e.neg);
                check("is_min64", min64, e.min);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!reset && outValid8) begin
            if (q8.size() == 0) check("spurious out_valid8", outValid8, 0);
            else begin
                e = q8.pop_front();
                check("result8", result8, e.mag);
                check("is_negative8", neg8, e.neg);
                check("is_min8", min8, e.min);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t64[8];
        vec_t t8[5];
        t64[0] = '{64'd5, 64'd5, 1'b0, 1'b0};
        t64[1] = '{64'd0, 64'd0, 1'b0, 1'b0};
        t64[2] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 1'b1, 1'b0};
        t64[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        t64[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
        t64[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0};
        t64[6] = '{64'd7, 64'd7, 1'b0, 1'b0};
        t64[7] = '{64'hFFFF_FFFF_FFFF_FF80, 64'd128, 1'b1, 1'b0};
        t8[0]  = '{64'hF8, 64'h08, 1'b1, 1'b0};
        t8[1]  = '{64'h80, 64'h80, 1'b1, 1'b1};
        t8[2]  = '{64'h7F, 64'h7F, 1'b0, 1'b0};
        t8[3]  = '{64'h00, 64'h00, 1'b0, 1'b0};
        t8[4]  = '{64'hFF, 64'h01, 1'b1, 1'b0};

        reset = 1'b1;
        inValid64 = 1'b0;
        inValid8 = 1'b0;
        value64 = '0;
        value8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result64", result64, 0);
        check("reset is_negative64", neg64, 0);
        check("reset is_min64", min64, 0);
        check("reset out_valid64", outValid64, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle out_valid64", outValid64, 0);

        // Back-to-back stream through the wide instance, ending -1, 7, -128.
        foreach (t64[i]) begin
            inValid64 = 1'b1;
            value64 = t64[i].value;
            q64.push_back('{t64[i].mag, t64[i].neg, t64[i].min});
            @(posedge clk);
            #1;
        end
        inValid64 = 1'b0;
        value64 = 64'd99;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold out_valid64", outValid64, 0);
            check("hold result64", result64, 64'd128);
            check("hold is_negative64", neg64, 1);
        end
        check("drain64", q64.size(), 0);

        foreach (t8[i]) begin
            inValid8 = 1'b1;
            value8 = t8[i].value[7:0];
            q8.push_back('{t8[i].mag, t8[i].neg, t8[i].min});
            @(posedge clk);
            #1;
        end
        inValid8 = 1'b0;
        for (int k = 0; k < 10 && q8.size() > 0; k++) @(posedge clk);
        #1;
        check("drain8", q8.size(), 0);
        check("hold result8", result8, 8'h01);
        check("hold out_valid8", outValid8, 0);

        // Asynchronous reset mid-stream, between clock edges.
        inValid64 = 1'b1;
        value64 = 64'hFFFF_FFFF_FFFF_FFFD;
        @(posedge clk);
        #2;
        check("pre-reset out_valid64", outValid64, 1);
        check("pre-reset result64", result64, 64'd3);
        reset = 1'b1;
        inValid64 = 1'b0;
        #1;
        check("async result64", result64, 0);
        check("async is_negative64", neg64, 0);
        check("async is_min64", min64, 0);
        check("async out_valid64", outValid64, 0);
        check("async result8", result8, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post-reset out_valid64", outValid64, 0);
        end
        inValid64 = 1'b1;
        value64 = 64'hFFFF_FFFF_FFFF_FFFB;
        q64.push_back('{64'd5, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        inValid64 = 1'b0;
        for (int k = 0; k < 10 && q64.size() > 0; k++) @(posedge clk);
        #1;
        check("drain post-reset64", q64.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
